// File: rtl/pkt_out_arbiter.sv
// pkt_out_arbiter: packet round-robin arbiter draining NPORT input FIFOs (in_empty/in_data/in_rd_en) into one output FIFO (out_ordy/out_wr_en/out_data), with grant/busy/err_ovr status
module pkt_out_arbiter #(
  parameter int NPORT  = 5,
  parameter int FW     = 34,
  parameter int PKTLEN = 4,
  parameter int CW     = 3
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [NPORT-1:0]    in_empty,
  input  logic [NPORT*FW-1:0] in_data,
  output logic [NPORT-1:0]    in_rd_en,
  input  logic                out_ordy,
  output logic                out_wr_en,
  output logic [FW-1:0]       out_data,
  output logic [NPORT-1:0]    grant,
  output logic                busy,
  output logic                err_ovr
);
  localparam int PW = NPORT > 1 ? $clog2(NPORT) : 1;
  typedef enum logic {IDLE, XFER} state_t;
  state_t state;
  logic [PW-1:0] g, rr_ptr, sel;
  logic [CW-1:0] flit_cnt;
  logic [NPORT-1:0] elig;
  logic [FW-1:0] cur;
  logic found, xfer, tail, last;
  always_comb begin
    elig = '0;
    for (int i = 0; i < NPORT; i++) elig[i] = ~in_empty[i] & in_data[i*FW + FW-2];
  end
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = NPORT-1; k >= 0; k--)
      if (elig[(int'(rr_ptr) + k) % NPORT]) begin
        found = 1'b1;
        sel = PW'((int'(rr_ptr) + k) % NPORT);
      end
  end
  assign busy      = state == XFER;
  assign cur       = in_data[g*FW +: FW];
  assign xfer      = busy & ~in_empty[g];
  assign in_rd_en  = xfer ? NPORT'(1) << g : '0;
  assign out_wr_en = xfer;
  assign out_data  = xfer ? cur : '0;
  assign tail      = cur[FW-1];
  assign last      = tail | (flit_cnt == CW'(PKTLEN-1));
  always_ff @(posedge clk or posedge rst_)
    if (rst_) begin
      state    <= IDLE;
      grant    <= '0;
      g        <= '0;
      rr_ptr   <= '0;
      flit_cnt <= '0;
      err_ovr  <= 1'b0;
    end else if (state == IDLE) begin
      if (out_ordy && found) begin
        state    <= XFER;
        grant    <= NPORT'(1) << sel;
        g        <= sel;
        flit_cnt <= '0;
      end
    end else if (xfer) begin
      flit_cnt <= last ? '0 : flit_cnt + 1'b1;
      if (last) begin
        state   <= IDLE;
        grant   <= '0;
        rr_ptr  <= g == PW'(NPORT-1) ? '0 : g + 1'b1;
        err_ovr <= err_ovr | ~tail;
      end
    end
endmodule

// File: tb/tb_pkt_out_arbiter.sv
// tb_pkt_out_arbiter: scoreboard bench with packet-level reference model for pkt_out_arbiter
module tb_pkt_out_arbiter;
  localparam int NPORT = 5, FW = 34, PKTLEN = 4, CW = 3;
  logic clk = 0, rst_ = 1, out_ordy = 1;
  logic out_wr_en, busy, err_ovr;
  logic [NPORT-1:0] in_empty, in_rd_en, grant, rd_s;
  logic [NPORT*FW-1:0] in_data;
  logic [FW-1:0] out_data;
  pkt_out_arbiter #(.NPORT(NPORT), .FW(FW), .PKTLEN(PKTLEN), .CW(CW)) dut (
    .clk(clk), .rst_(rst_), .in_empty(in_empty), .in_data(in_data), .in_rd_en(in_rd_en),
    .out_ordy(out_ordy), .out_wr_en(out_wr_en), .out_data(out_data), .grant(grant),
    .busy(busy), .err_ovr(err_ovr));
  always #5 clk = ~clk;
  logic [FW-1:0] q [NPORT][$];
  logic [FW-1:0] expq [$];
  bit hold [NPORT];
  bit rand_mode, m_busy, m_ovr, m_povr;
  int n_tests, n_fail, n_wr, m_owner, m_rr, m_rem, w;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit vis(int j);
    return q[j].size() != 0 && !hold[j];
  endfunction
  task automatic drive();
    for (int i = 0; i < NPORT; i++) begin
      in_empty[i] = !vis(i);
      in_data[i*FW +: FW] = q[i].size() != 0 ? q[i][0] : '0;
    end
  endtask
  task automatic add_pkt(int p, int len, bit ovr);
    for (int i = 0; i < len; i++) begin
      logic [1:0] t;
      t = (len == 1 && !ovr) ? 2'b11 : i == 0 ? 2'b01 : (i == len-1 && !ovr) ? 2'b10 : 2'b00;
      q[p].push_back({t, 32'($urandom)});
    end
  endtask
  task automatic model_step();
    logic [NPORT-1:0] eg;
    bit fin;
    eg = m_busy ? NPORT'(1) << m_owner : '0;
    chk("grant", grant, eg);
    chk("busy", busy, m_busy);
    chk("err_ovr", err_ovr, m_ovr);
    if (m_busy) begin
      chk("rd_en", in_rd_en, vis(m_owner) ? eg : '0);
      if (vis(m_owner)) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0;
          m_rr = (m_owner + 1) % NPORT;
          m_ovr = m_ovr | m_povr;
        end
      end
    end else begin
      chk("rd_en_idle", in_rd_en, 0);
      if (out_ordy)
        for (int k = 0; k < NPORT && !m_busy; k++) begin
          int j;
          j = (m_rr + k) % NPORT;
          if (vis(j) && q[j][0][FW-2]) begin
            m_busy = 1;
            m_owner = j;
            m_rem = 0;
            fin = 0;
            while (!fin) begin
              expq.push_back(q[j][m_rem]);
              m_rem++;
              fin = q[j][m_rem-1][FW-1] || m_rem == PKTLEN;
            end
            m_povr = !q[j][m_rem-1][FW-1];
          end
        end
    end
  endtask
  initial forever begin
    @(negedge clk);
    rd_s = in_rd_en;
    if (!rst_) model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NPORT; i++) if (rd_s[i] && q[i].size() != 0) void'(q[i].pop_front());
    if (rand_mode) for (int i = 0; i < NPORT; i++) hold[i] = $urandom_range(3) == 0;
    drive();
  end
  always @(negedge clk)
    if (!rst_) begin
      if (out_wr_en) begin
        n_wr++;
        chk("wr_pending", expq.size() != 0, 1);
        if (expq.size() != 0) chk("out_data", out_data, expq.pop_front());
      end else chk("out_data_idle", out_data, 0);
    end
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  function automatic bit pending(int mask);
    for (int i = 0; i < NPORT; i++) if (mask[i] && q[i].size() != 0) return 1;
    return 0;
  endfunction
  task automatic drain(int mask);
    int c;
    c = 0;
    while (c < 500 && (m_busy || pending(mask))) begin
      cyc(1);
      c++;
    end
    chk("drain_timeout", c < 500, 1);
  endtask
  task automatic wait_owner(int p);
    int c;
    c = 0;
    while (c < 100 && !(m_busy && m_owner == p)) begin
      cyc(1);
      c++;
    end
    chk("owner_timeout", c < 100, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    drive();
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_ovr", err_ovr, 0);
    chk("rst_rd_en", in_rd_en, 0);
    chk("rst_wr_en", out_wr_en, 0);
    chk("rst_out_data", out_data, 0);
    cyc(1);
    rst_ = 0;
    add_pkt(0, 3, 0);
    add_pkt(1, 3, 0);
    add_pkt(4, 3, 0);
    drive();
    w = n_wr;
    drain(31);
    chk("contention_writes", n_wr - w, 9);
    add_pkt(2, 1, 0);
    drive();
    w = n_wr;
    drain(31);
    chk("single_writes", n_wr - w, 1);
    out_ordy = 0;
    add_pkt(3, 2, 0);
    drive();
    cyc(5);
    chk("stall_grant", grant, 0);
    out_ordy = 1;
    drain(31);
    add_pkt(1, 3, 0);
    drive();
    w = n_wr;
    wait_owner(1);
    cyc(1);
    hold[1] = 1;
    add_pkt(0, 2, 0);
    drive();
    cyc(3);
    chk("bubble_grant", grant, 5'b00010);
    hold[1] = 0;
    drive();
    drain(31);
    chk("bubble_writes", n_wr - w, 5);
    add_pkt(0, 4, 1);
    drive();
    drain(31);
    chk("ovr_set", err_ovr, 1);
    rand_mode = 1;
    for (int c = 0; c < 400; c++) begin
      cyc(1);
      out_ordy = $urandom_range(3) != 0;
      for (int i = 0; i < NPORT; i++)
        if (q[i].size() < 6 && $urandom_range(7) == 0) add_pkt(i, $urandom_range(1, PKTLEN), 0);
      drive();
    end
    rand_mode = 0;
    for (int i = 0; i < NPORT; i++) hold[i] = 0;
    out_ordy = 1;
    drive();
    drain(31);
    chk("ovr_sticky", err_ovr, 1);
    add_pkt(0, 4, 0);
    drive();
    wait_owner(0);
    cyc(2);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_rd_en", in_rd_en, 1);
    rst_ = 1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", in_rd_en, 0);
    chk("arst_wr_en", out_wr_en, 0);
    chk("arst_err_ovr", err_ovr, 0);
    m_busy = 0;
    m_rr = 0;
    m_ovr = 0;
    m_povr = 0;
    expq.delete();
    cyc(2);
    rst_ = 0;
    add_pkt(1, 2, 0);
    add_pkt(3, 1, 0);
    drive();
    drain(5'b11110);
    cyc(10);
    chk("residual_kept", q[0].size(), 2);
    q[0].delete();
    drive();
    cyc(2);
    chk("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
